// File: rtl/mc_control_if.sv
// mc_control_if: control bus between the multi-cycle control FSM and the
// MIPS-subset datapath.
//   master : control unit side (receives opcode/funct/zero, drives controls)
//   slave  : datapath side (drives opcode/funct/zero, receives controls)
// Signals:
//   opcode, funct  instruction register fields instr[31:26] / instr[5:0]
//   zero           ALU zero flag, same cycle
//   alu_command    ALU op: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
//   alu_src_a/b, zero_ext, pc_we, pc_src, iord, ir_we, mem_we, reg_we,
//   reg_dst, mem_to_reg  datapath selects and write enables
//   retire, illegal      one-cycle status pulses
//   instr_count          retired-instruction counter, CNT_W bits
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic [2:0]       alu_command;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             zero_ext;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             iord;
    logic             ir_we;
    logic             mem_we;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero,
        output alu_command, alu_src_a, alu_src_b, zero_ext, pc_we, pc_src,
               iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
               retire, illegal, instr_count
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_command, alu_src_a, alu_src_b, zero_ext, pc_we, pc_src,
               iord, ir_we, mem_we, reg_we, reg_dst, mem_to_reg,
               retire, illegal, instr_count
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback, drives ALU command,
// datapath selects and write enables, resolves BNE from the ALU zero flag
// and counts retired instructions.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high; returns to FETCH and clears the counter
//   bus    mc_control_if.master (instruction fields in, controls out)
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | IR <= mem[PC], PC <= PC+4
// DECODE   | ALUOut <= branch target, dispatch on opcode/funct
// MEM_ADDR | ALUOut <= regA + sext imm
// MEM_RD   | MDR <= mem[ALUOut]
// MEM_WB   | rt <= MDR (LW retires)
// MEM_WR   | mem[ALUOut] <= regB (SW retires)
// EX_R     | ALUOut <= regA op regB
// WB_R     | rd <= ALUOut (R-type retires)
// EX_BNE   | PC <= ALUOut if regA != regB (retires)
// EX_J     | PC <= jump target (retires)
// EX_JR    | PC <= regA (retires)
// EX_JAL   | $31 <= PC, PC <= jump target (retires)
// EX_ADDI  | ALUOut <= regA + sext imm
// EX_XORI  | ALUOut <= regA ^ zext imm
// WB_I     | rt <= ALUOut (ADDI/XORI retire)
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EX_R     = 4'd6,
        WB_R     = 4'd7,
        EX_BNE   = 4'd8,
        EX_J     = 4'd9,
        EX_JR    = 4'd10,
        EX_JAL   = 4'd11,
        EX_ADDI  = 4'd12,
        EX_XORI  = 4'd13,
        WB_I     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        state_d             = FETCH;
        bus.alu_command     = ALU_ADD;
        bus.alu_src_a       = 1'b0;
        bus.alu_src_b       = 2'd0;
        bus.zero_ext        = 1'b0;
        bus.pc_we           = 1'b0;
        bus.pc_src          = 2'd0;
        bus.iord            = 1'b0;
        bus.ir_we           = 1'b0;
        bus.mem_we          = 1'b0;
        bus.reg_we          = 1'b0;
        bus.reg_dst         = 2'd0;
        bus.mem_to_reg      = 2'd0;
        bus.retire          = 1'b0;
        bus.illegal         = 1'b0;

        case (state_q)
            FETCH: begin
                bus.ir_we     = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.pc_we     = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'd3;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BNE:       state_d = EX_BNE;
                    OP_J:         state_d = EX_J;
                    OP_JAL:       state_d = EX_JAL;
                    OP_ADDI:      state_d = EX_ADDI;
                    OP_XORI:      state_d = EX_XORI;
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = EX_R;
                            FN_JR:                  state_d = EX_JR;
                            default:                bus.illegal = 1'b1;
                        endcase
                    end
                    default: bus.illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_d       = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.iord = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 2'd1;
                bus.retire     = 1'b1;
            end
            MEM_WR: begin
                bus.iord   = 1'b1;
                bus.mem_we = 1'b1;
                bus.retire = 1'b1;
            end
            EX_R: begin
                bus.alu_src_a = 1'b1;
                case (bus.funct)
                    FN_SUB:  bus.alu_command = ALU_SUB;
                    FN_SLT:  bus.alu_command = ALU_SLT;
                    default: bus.alu_command = ALU_ADD;
                endcase
                state_d = WB_R;
            end
            WB_R: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = 2'd1;
                bus.retire  = 1'b1;
            end
            EX_BNE: begin
                // ALU compares regA-regB; ALUOut holds the target from DECODE
                bus.alu_src_a   = 1'b1;
                bus.alu_command = ALU_SUB;
                bus.pc_src      = 2'd1;
                bus.pc_we       = ~bus.zero;
                bus.retire      = 1'b1;
            end
            EX_J: begin
                bus.pc_src = 2'd2;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
            end
            EX_JR: begin
                bus.pc_src = 2'd3;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
            end
            EX_JAL: begin
                // link value is the current PC, already PC+4 since FETCH
                bus.pc_src     = 2'd2;
                bus.pc_we      = 1'b1;
                bus.reg_we     = 1'b1;
                bus.reg_dst    = 2'd2;
                bus.mem_to_reg = 2'd2;
                bus.retire     = 1'b1;
            end
            EX_ADDI: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_d       = WB_I;
            end
            EX_XORI: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.zero_ext    = 1'b1;
                bus.alu_command = ALU_XOR;
                state_d         = WB_I;
            end
            WB_I: begin
                bus.reg_we = 1'b1;
                bus.retire = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // No side effects may leak out while reset is held.
        if (reset) begin
            bus.pc_we   = 1'b0;
            bus.ir_we   = 1'b0;
            bus.mem_we  = 1'b0;
            bus.reg_we  = 1'b0;
            bus.retire  = 1'b0;
            bus.illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (bus.retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(CNT_W)) bus ();
    mc_control #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [2:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       zx;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       iord;
        logic       irwe;
        logic       memwe;
        logic       regwe;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       ret;
        logic       ill;
    } ctl_t;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    function automatic ctl_t actual();
        ctl_t a;
        a.alu   = bus.alu_command;
        a.sa    = bus.alu_src_a;
        a.sb    = bus.alu_src_b;
        a.zx    = bus.zero_ext;
        a.pcwe  = bus.pc_we;
        a.pcsrc = bus.pc_src;
        a.iord  = bus.iord;
        a.irwe  = bus.ir_we;
        a.memwe = bus.mem_we;
        a.regwe = bus.reg_we;
        a.rdst  = bus.reg_dst;
        a.m2r   = bus.mem_to_reg;
        a.ret   = bus.retire;
        a.ill   = bus.illegal;
        return a;
    endfunction

    // Cycles from FETCH to retire inclusive; 2 for anything unsupported.
    function automatic int latency(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h08, 6'h0E: return 4;
            6'h05, 6'h02, 6'h03: return 3;
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return 4;
                if (fn == 6'h08) return 3;
                return 2;
            end
            default: return 2;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(logic [5:0] op, logic [5:0] fn, int cyc, logic z);
        ctl_t e = '0;
        int   lat = latency(op, fn);
        if (cyc == 0) begin
            e.irwe = 1; e.sb = 2'd1; e.pcwe = 1;
            return e;
        end
        if (cyc == 1) begin
            e.sb  = 2'd3;
            e.ill = (lat == 2);
            return e;
        end
        case (op)
            6'h23: begin
                if (cyc == 2) begin e.sa = 1; e.sb = 2'd2; end
                if (cyc == 3) e.iord = 1;
                if (cyc == 4) begin e.regwe = 1; e.m2r = 2'd1; end
            end
            6'h2B: begin
                if (cyc == 2) begin e.sa = 1; e.sb = 2'd2; end
                if (cyc == 3) begin e.iord = 1; e.memwe = 1; end
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    e.pcsrc = 2'd3; e.pcwe = 1;
                end else if (cyc == 2) begin
                    e.sa  = 1;
                    e.alu = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
                end else begin
                    e.regwe = 1; e.rdst = 2'd1;
                end
            end
            6'h05: begin
                e.sa = 1; e.alu = 3'd1; e.pcsrc = 2'd1; e.pcwe = ~z;
            end
            6'h02: begin
                e.pcsrc = 2'd2; e.pcwe = 1;
            end
            6'h03: begin
                e.pcsrc = 2'd2; e.pcwe = 1; e.regwe = 1; e.rdst = 2'd2; e.m2r = 2'd2;
            end
            6'h08, 6'h0E: begin
                if (cyc == 2) begin
                    e.sa = 1; e.sb = 2'd2;
                    if (op == 6'h0E) begin e.zx = 1; e.alu = 3'd2; end
                end else begin
                    e.regwe = 1;
                end
            end
            default: ;
        endcase
        e.ret = (cyc == lat - 1);
        return e;
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after
    // the last driven cycle. ncyc <= 0 runs the whole instruction.
    // zmode: 0 random zero, 1 zero=0, 2 zero=1.
    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int zmode, int ncyc);
        int   n;
        logic z;
        ctl_t a, e;
        bus.opcode = op;
        bus.funct  = fn;
        n = (ncyc <= 0) ? latency(op, fn) : ncyc;
        for (int c = 0; c < n; c++) begin
            z = (zmode == 0) ? 1'($urandom_range(1)) : (zmode == 2);
            bus.zero = z;
            #1;
            a = actual();
            e = expect_ctl(op, fn, c, z);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc%0d op=%h fn=%h z=%b: got ctl=%h expected ctl=%h",
                         name, c, op, fn, z, a, e);
            end
            @(negedge clk);
        end
        if (ncyc <= 0) begin
            if (latency(op, fn) > 2) model_count = (model_count + 1) % (1 << CNT_W);
            checks++;
            if (bus.instr_count !== CNT_W'(model_count)) begin
                errors++;
                $display("FAIL %s count op=%h fn=%h: got %0d expected %0d",
                         name, op, fn, bus.instr_count, model_count);
            end
        end
    endtask

    // Two-cycle reset starting from whatever state the DUT is in.
    task automatic apply_reset(string name);
        ctl_t a;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            a = actual();
            checks++;
            if ({a.pcwe, a.regwe, a.memwe, a.irwe, a.ret, a.ill} !== 6'b0) begin
                errors++;
                $display("FAIL %s enables_in_reset: got pcwe=%b regwe=%b memwe=%b irwe=%b ret=%b ill=%b expected all 0",
                         name, a.pcwe, a.regwe, a.memwe, a.irwe, a.ret, a.ill);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        model_count = 0;
        #1;
        checks++;
        if (bus.instr_count !== '0) begin
            errors++;
            $display("FAIL %s count_after_reset: got %0d expected 0", name, bus.instr_count);
        end
        checks++;
        if (bus.ir_we !== 1'b1 || bus.pc_we !== 1'b1) begin
            errors++;
            $display("FAIL %s fetch_after_reset: got ir_we=%b pc_we=%b expected 1 1",
                     name, bus.ir_we, bus.pc_we);
        end
    endtask

    task automatic test_reset();
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        apply_reset("reset");
    endtask

    task automatic test_lw();
        run_instr("lw", 6'h23, 6'(6'h3F & $urandom), 0, 0);
    endtask

    task automatic test_rtype();
        run_instr("slt", 6'h00, 6'h2A, 0, 0);
        run_instr("sub", 6'h00, 6'h22, 0, 0);
        run_instr("add", 6'h00, 6'h20, 0, 0);
        run_instr("jr",  6'h00, 6'h08, 0, 0);
        run_instr("ill_funct", 6'h00, 6'h27, 0, 0);
        run_instr("ill_op", 6'h3F, 6'h20, 0, 0);
    endtask

    task automatic test_bne();
        run_instr("bne_taken_no", 6'h05, 6'h00, 2, 0);
        run_instr("bne_taken_yes", 6'h05, 6'h00, 1, 0);
    endtask

    task automatic test_jal_xori();
        run_instr("jal", 6'h03, 6'h15, 0, 0);
        run_instr("j", 6'h02, 6'h01, 0, 0);
        run_instr("xori", 6'h0E, 6'h2A, 0, 0);
        run_instr("addi", 6'h08, 6'h22, 0, 0);
        run_instr("sw", 6'h2B, 6'h00, 0, 0);
    endtask

    task automatic test_reset_mid_lw();
        run_instr("lw_partial", 6'h23, 6'h00, 0, 3);
        apply_reset("reset_mid_lw");
        run_instr("after_reset", 6'h0E, 6'h00, 0, 0);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        apply_reset("wrap_reset");
        for (int i = 0; i < 15; i++) run_instr("sw_fill", 6'h2B, 6'h00, 0, 0);
        checks++;
        if (bus.instr_count !== 4'hF) begin
            errors++;
            $display("FAIL wrap_pre: got %0d expected 15", bus.instr_count);
        end
        run_instr("sw_wrap", 6'h2B, 6'h00, 0, 0);
        checks++;
        if (bus.instr_count !== 4'h0) begin
            errors++;
            $display("FAIL wrap_post: got %0d expected 0", bus.instr_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h05, 6'h02, 6'h03, 6'h08, 6'h0E};
        logic [5:0] fns[11] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h2A, 6'h08,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        logic [5:0] op, fn;
        int k;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                k  = $urandom_range(10);
                op = ops[k];
                fn = (op == 6'h00) ? fns[k] : 6'($urandom);
            end
            run_instr("random", op, fn, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_bne();
        test_jal_xori();
        test_reset_mid_lw();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
